// File: rtl/multicycle_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl_fsm
// Description : Main control sequencer for a multi-cycle RV32I core. It steps
//               each instruction through fetch, decode, execute, memory and
//               writeback. It drives the datapath mux selects, write enables,
//               ALU op class and immediate format select. It waits on a
//               memory ready handshake and counts retired instructions.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk           in   clock, all state updates on rising edge
//   rst           in   synchronous active-high reset
//   op[6:0]       in   opcode field of the instruction register
//   funct3[2:0]   in   funct3 field (not used for sequencing)
//   zero          in   ALU zero flag
//   mem_ready     in   memory completes the current access this cycle
//   pc_write      out  PC register enable
//   adr_src       out  memory address select: 0 PC, 1 ALUOut
//   mem_write     out  data memory write request
//   ir_write      out  IR / old-PC capture enable
//   result_src    out  00 ALUOut, 01 mem data, 10 ALU result
//   alu_src_a     out  00 PC, 01 old PC, 10 rs1
//   alu_src_b     out  00 rs2, 01 immediate, 10 constant 4
//   alu_op        out  00 add, 01 subtract, 10 funct-decoded
//   reg_write     out  register file write enable
//   imm_src       out  immediate format: 00 I, 01 S, 10 B, 11 J
//   instr_done    out  one-cycle pulse when an instruction retires
//   instret       out  retired-instruction counter (wraps)
//   illegal_instr out  sticky illegal-opcode flag
// Build option
//   ILLEGAL_TRAP_EN : when defined, an unknown opcode parks the FSM in TRAP
//                     and raises illegal_instr until rst. When undefined the
//                     opcode is treated as a NOP and illegal_instr is 0.
// ============================================================================
module multicycle_ctrl_fsm #(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 pc_write,
  output logic                 adr_src,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic [1:0]           result_src,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           alu_op,
  output logic                 reg_write,
  output logic [1:0]           imm_src,
  output logic                 instr_done,
  output logic [INSTRET_W-1:0] instret,
  output logic                 illegal_instr
);

  localparam logic [6:0] c_op_load  = 7'b0000011;
  localparam logic [6:0] c_op_store = 7'b0100011;
  localparam logic [6:0] c_op_rtype = 7'b0110011;
  localparam logic [6:0] c_op_itype = 7'b0010011;
  localparam logic [6:0] c_op_beq   = 7'b1100011;
  localparam logic [6:0] c_op_jal   = 7'b1101111;

  localparam logic [INSTRET_W-1:0] c_instret_one = INSTRET_W'(1);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  state_t                 r_state;
  state_t                 w_next_state;
  logic [INSTRET_W-1:0]   r_instret;

  // Ungated enables; rst masks them below so nothing is written during reset.
  logic w_pc_update;
  logic w_branch;
  logic w_ir_write;
  logic w_mem_write;
  logic w_reg_write;
  logic w_instr_done;

  // funct3 is reserved for future decode; fold it into a named sink.
  logic w_unused;
  assign w_unused = ^funct3;

  // --------------------------------------------------------------------------
  // State register and retired-instruction counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_instret <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_instr_done) begin
        r_instret <= r_instret + c_instret_one;
      end
    end
  end

  assign instret = r_instret;

  // --------------------------------------------------------------------------
  // Next-state and Moore output decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    w_pc_update  = 1'b0;
    w_branch     = 1'b0;
    w_ir_write   = 1'b0;
    w_mem_write  = 1'b0;
    w_reg_write  = 1'b0;
    w_instr_done = 1'b0;
    adr_src      = 1'b0;
    result_src   = 2'b00;
    alu_src_a    = 2'b00;
    alu_src_b    = 2'b00;
    alu_op       = 2'b00;

    case (r_state)
      S_FETCH: begin
        // PC+4 is computed every fetch cycle but only committed with the IR.
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b10;
        alu_op      = 2'b00;
        result_src  = 2'b10;
        w_ir_write  = mem_ready;
        w_pc_update = mem_ready;
        if (mem_ready) begin
          w_next_state = S_DECODE;
        end
      end

      S_DECODE: begin
        // Branch target (old PC + imm) lands in ALUOut for a following BEQ.
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        alu_op    = 2'b00;
        case (op)
          c_op_load, c_op_store: w_next_state = S_MEMADR;
          c_op_rtype:            w_next_state = S_EXECR;
          c_op_itype:            w_next_state = S_EXECI;
          c_op_beq:              w_next_state = S_BEQ;
          c_op_jal:              w_next_state = S_JAL;
`ifdef ILLEGAL_TRAP_EN
          default:               w_next_state = S_TRAP;
`else
          default:               w_next_state = S_FETCH;
`endif
        endcase
      end

      S_MEMADR: begin
        alu_src_a    = 2'b10;
        alu_src_b    = 2'b01;
        alu_op       = 2'b00;
        w_next_state = (op == c_op_load) ? S_MEMREAD : S_MEMWRITE;
      end

      S_MEMREAD: begin
        adr_src    = 1'b1;
        result_src = 2'b00;
        if (mem_ready) begin
          w_next_state = S_MEMWB;
        end
      end

      S_MEMWB: begin
        result_src   = 2'b01;
        w_reg_write  = 1'b1;
        w_instr_done = 1'b1;
        w_next_state = S_FETCH;
      end

      S_MEMWRITE: begin
        // The write request stays up through the cycle memory accepts it.
        adr_src      = 1'b1;
        result_src   = 2'b00;
        w_mem_write  = 1'b1;
        w_instr_done = mem_ready;
        if (mem_ready) begin
          w_next_state = S_FETCH;
        end
      end

      S_EXECR: begin
        alu_src_a    = 2'b10;
        alu_src_b    = 2'b00;
        alu_op       = 2'b10;
        w_next_state = S_ALUWB;
      end

      S_EXECI: begin
        alu_src_a    = 2'b10;
        alu_src_b    = 2'b01;
        alu_op       = 2'b10;
        w_next_state = S_ALUWB;
      end

      S_ALUWB: begin
        result_src   = 2'b00;
        w_reg_write  = 1'b1;
        w_instr_done = 1'b1;
        w_next_state = S_FETCH;
      end

      S_BEQ: begin
        // Target was precomputed in DECODE; the subtract only sets zero.
        alu_src_a    = 2'b10;
        alu_src_b    = 2'b00;
        alu_op       = 2'b01;
        result_src   = 2'b00;
        w_branch     = 1'b1;
        w_instr_done = 1'b1;
        w_next_state = S_FETCH;
      end

      S_JAL: begin
        // Jump target from DECODE goes to PC; ALU forms old PC + 4 for rd.
        alu_src_a    = 2'b01;
        alu_src_b    = 2'b10;
        alu_op       = 2'b00;
        result_src   = 2'b00;
        w_pc_update  = 1'b1;
        w_next_state = S_ALUWB;
      end

      S_TRAP: begin
`ifdef ILLEGAL_TRAP_EN
        w_next_state = S_TRAP;
`else
        w_next_state = S_FETCH;
`endif
      end

      default: begin
        w_next_state = S_FETCH;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Reset-gated enables
  // --------------------------------------------------------------------------
  assign pc_write   = ~rst & (w_pc_update | (w_branch & zero));
  assign ir_write   = ~rst & w_ir_write;
  assign mem_write  = ~rst & w_mem_write;
  assign reg_write  = ~rst & w_reg_write;
  assign instr_done = ~rst & w_instr_done;

  // --------------------------------------------------------------------------
  // Immediate format select, decoded straight from the opcode
  // --------------------------------------------------------------------------
  always_comb begin
    imm_src = 2'b00;
    case (op)
      c_op_load, c_op_itype: imm_src = 2'b00;
      c_op_store:            imm_src = 2'b01;
      c_op_beq:              imm_src = 2'b10;
      c_op_jal:              imm_src = 2'b11;
      default:               imm_src = 2'b00;
    endcase
  end

  // --------------------------------------------------------------------------
  // Illegal-opcode flag
  // --------------------------------------------------------------------------
`ifdef ILLEGAL_TRAP_EN
  logic r_illegal;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_illegal <= 1'b0;
    end else if ((r_state == S_DECODE) && (w_next_state == S_TRAP)) begin
      r_illegal <= 1'b1;
    end
  end

  assign illegal_instr = r_illegal;
`else
  assign illegal_instr = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_ctrl_fsm
// Description : Self-checking bench for multicycle_ctrl_fsm. A table of
//               per-cycle {inputs, expected outputs} rows walks every
//               instruction class; hand-written sequences cover counter wrap,
//               reset during a store wait and the illegal-opcode path.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl_fsm;

  localparam int INSTRET_W = 3;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_L = 7'b0000011;
  localparam logic [6:0] OP_S = 7'b0100011;
  localparam logic [6:0] OP_B = 7'b1100011;
  localparam logic [6:0] OP_J = 7'b1101111;
  localparam logic [6:0] OP_X = 7'b0000000;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [6:0]           op;
  logic [2:0]           funct3;
  logic                 zero;
  logic                 mem_ready;
  logic                 pc_write;
  logic                 adr_src;
  logic                 mem_write;
  logic                 ir_write;
  logic [1:0]           result_src;
  logic [1:0]           alu_src_a;
  logic [1:0]           alu_src_b;
  logic [1:0]           alu_op;
  logic                 reg_write;
  logic [1:0]           imm_src;
  logic                 instr_done;
  logic [INSTRET_W-1:0] instret;
  logic                 illegal_instr;

  multicycle_ctrl_fsm #(.INSTRET_W(INSTRET_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .op           (op),
    .funct3       (funct3),
    .zero         (zero),
    .mem_ready    (mem_ready),
    .pc_write     (pc_write),
    .adr_src      (adr_src),
    .mem_write    (mem_write),
    .ir_write     (ir_write),
    .result_src   (result_src),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_op       (alu_op),
    .reg_write    (reg_write),
    .imm_src      (imm_src),
    .instr_done   (instr_done),
    .instret      (instret),
    .illegal_instr(illegal_instr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [6:0] op;
    logic       zero;
    logic       rdy;
    logic       chk_sel;
    logic       pcw;
    logic       adr;
    logic       mw;
    logic       irw;
    logic [1:0] rs;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] aop;
    logic       rw;
    logic [1:0] imm;
    logic       done;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;
  logic [INSTRET_W-1:0] exp_instret;

  function automatic void add(input logic r, input logic [6:0] o, input logic z,
                              input logic rd, input logic cs, input logic pcw,
                              input logic adr, input logic mw, input logic irw,
                              input logic [1:0] rs, input logic [1:0] a,
                              input logic [1:0] b, input logic [1:0] aop,
                              input logic rw, input logic [1:0] imm,
                              input logic done);
    vec_t v;
    v.rst = r; v.op = o; v.zero = z; v.rdy = rd; v.chk_sel = cs;
    v.pcw = pcw; v.adr = adr; v.mw = mw; v.irw = irw; v.rs = rs;
    v.a = a; v.b = b; v.aop = aop; v.rw = rw; v.imm = imm; v.done = done;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [6:0] o, input logic z, input logic rd);
    rst = r; op = o; zero = z; mem_ready = rd;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // FETCH is recognisable by its unique select pattern.
  task automatic chk_fetch(input string nm);
    chk(nm, {28'd0, result_src, alu_src_b}, {28'd0, 2'b10, 2'b10});
  endtask

  initial begin
    rst = 1'b1; op = OP_R; funct3 = 3'b000; zero = 1'b0; mem_ready = 1'b1;
    exp_instret = '0;

    //   rst op   z rdy cs  pcw adr mw irw  rs a  b  aop  rw imm done
    add(1, OP_R, 0, 1, 0,  0, 0, 0, 0,  2, 0, 2, 0,  0, 0, 0);
    add(1, OP_R, 0, 1, 1,  0, 0, 0, 0,  2, 0, 2, 0,  0, 0, 0);
    // R-type
    add(0, OP_R, 0, 1, 1,  1, 0, 0, 1,  2, 0, 2, 0,  0, 0, 0);
    add(0, OP_R, 0, 1, 1,  0, 0, 0, 0,  0, 1, 1, 0,  0, 0, 0);
    add(0, OP_R, 0, 1, 1,  0, 0, 0, 0,  0, 2, 0, 2,  0, 0, 0);
    add(0, OP_R, 0, 1, 1,  0, 0, 0, 0,  0, 0, 0, 0,  1, 0, 1);
    // beq taken
    add(0, OP_B, 1, 1, 1,  1, 0, 0, 1,  2, 0, 2, 0,  0, 2, 0);
    add(0, OP_B, 1, 1, 1,  0, 0, 0, 0,  0, 1, 1, 0,  0, 2, 0);
    add(0, OP_B, 1, 1, 1,  1, 0, 0, 0,  0, 2, 0, 1,  0, 2, 1);
    // beq not taken (zero high in DECODE must not write PC)
    add(0, OP_B, 0, 1, 1,  1, 0, 0, 1,  2, 0, 2, 0,  0, 2, 0);
    add(0, OP_B, 1, 1, 1,  0, 0, 0, 0,  0, 1, 1, 0,  0, 2, 0);
    add(0, OP_B, 0, 1, 1,  0, 0, 0, 0,  0, 2, 0, 1,  0, 2, 1);
    // jal
    add(0, OP_J, 0, 1, 1,  1, 0, 0, 1,  2, 0, 2, 0,  0, 3, 0);
    add(0, OP_J, 0, 1, 1,  0, 0, 0, 0,  0, 1, 1, 0,  0, 3, 0);
    add(0, OP_J, 0, 1, 1,  1, 0, 0, 0,  0, 1, 2, 0,  0, 3, 0);
    add(0, OP_J, 0, 1, 1,  0, 0, 0, 0,  0, 0, 0, 0,  1, 3, 1);
    // sw: one fetch wait, mem_ready ignored in DECODE/MEMADR, two store waits
    add(0, OP_S, 0, 0, 1,  0, 0, 0, 0,  2, 0, 2, 0,  0, 1, 0);
    add(0, OP_S, 0, 1, 1,  1, 0, 0, 1,  2, 0, 2, 0,  0, 1, 0);
    add(0, OP_S, 0, 0, 1,  0, 0, 0, 0,  0, 1, 1, 0,  0, 1, 0);
    add(0, OP_S, 0, 0, 1,  0, 0, 0, 0,  0, 2, 1, 0,  0, 1, 0);
    add(0, OP_S, 0, 0, 1,  0, 1, 1, 0,  0, 0, 0, 0,  0, 1, 0);
    add(0, OP_S, 0, 0, 1,  0, 1, 1, 0,  0, 0, 0, 0,  0, 1, 0);
    add(0, OP_S, 0, 1, 1,  0, 1, 1, 0,  0, 0, 0, 0,  0, 1, 1);
    // lw: three read waits
    add(0, OP_L, 0, 1, 1,  1, 0, 0, 1,  2, 0, 2, 0,  0, 0, 0);
    add(0, OP_L, 0, 1, 1,  0, 0, 0, 0,  0, 1, 1, 0,  0, 0, 0);
    add(0, OP_L, 0, 1, 1,  0, 0, 0, 0,  0, 2, 1, 0,  0, 0, 0);
    add(0, OP_L, 0, 0, 1,  0, 1, 0, 0,  0, 0, 0, 0,  0, 0, 0);
    add(0, OP_L, 0, 0, 1,  0, 1, 0, 0,  0, 0, 0, 0,  0, 0, 0);
    add(0, OP_L, 0, 0, 1,  0, 1, 0, 0,  0, 0, 0, 0,  0, 0, 0);
    add(0, OP_L, 0, 1, 1,  0, 1, 0, 0,  0, 0, 0, 0,  0, 0, 0);
    add(0, OP_L, 0, 1, 1,  0, 0, 0, 0,  1, 0, 0, 0,  1, 0, 1);
    // I-type
    add(0, OP_I, 0, 1, 1,  1, 0, 0, 1,  2, 0, 2, 0,  0, 0, 0);
    add(0, OP_I, 0, 1, 1,  0, 0, 0, 0,  0, 1, 1, 0,  0, 0, 0);
    add(0, OP_I, 0, 1, 1,  0, 0, 0, 0,  0, 2, 1, 2,  0, 0, 0);
    add(0, OP_I, 0, 1, 1,  0, 0, 0, 0,  0, 0, 0, 0,  1, 0, 1);
    // R-type again: eighth retirement wraps the 3-bit counter
    add(0, OP_R, 0, 1, 1,  1, 0, 0, 1,  2, 0, 2, 0,  0, 0, 0);
    add(0, OP_R, 0, 1, 1,  0, 0, 0, 0,  0, 1, 1, 0,  0, 0, 0);
    add(0, OP_R, 0, 1, 1,  0, 0, 0, 0,  0, 2, 0, 2,  0, 0, 0);
    add(0, OP_R, 0, 1, 1,  0, 0, 0, 0,  0, 0, 0, 0,  1, 0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      v = vecs[i];
      drive(v.rst, v.op, v.zero, v.rdy);
      chk($sformatf("vec%0d.pc_write",   i), {31'd0, pc_write},   {31'd0, v.pcw});
      chk($sformatf("vec%0d.mem_write",  i), {31'd0, mem_write},  {31'd0, v.mw});
      chk($sformatf("vec%0d.ir_write",   i), {31'd0, ir_write},   {31'd0, v.irw});
      chk($sformatf("vec%0d.reg_write",  i), {31'd0, reg_write},  {31'd0, v.rw});
      chk($sformatf("vec%0d.instr_done", i), {31'd0, instr_done}, {31'd0, v.done});
      if (v.chk_sel) begin
        chk($sformatf("vec%0d.adr_src",    i), {31'd0, adr_src},    {31'd0, v.adr});
        chk($sformatf("vec%0d.result_src", i), {30'd0, result_src}, {30'd0, v.rs});
        chk($sformatf("vec%0d.alu_src_a",  i), {30'd0, alu_src_a},  {30'd0, v.a});
        chk($sformatf("vec%0d.alu_src_b",  i), {30'd0, alu_src_b},  {30'd0, v.b});
        chk($sformatf("vec%0d.alu_op",     i), {30'd0, alu_op},     {30'd0, v.aop});
        chk($sformatf("vec%0d.imm_src",    i), {30'd0, imm_src},    {30'd0, v.imm});
      end
      if (i > 0) begin
        chk($sformatf("vec%0d.instret", i), {29'd0, instret}, {29'd0, exp_instret});
      end
      if (v.rst) exp_instret = '0;
      else if (v.done) exp_instret = exp_instret + 3'd1;
      tick();
    end

    // Eight retirements on a 3-bit counter land back on zero.
    drive(0, OP_B, 0, 1);
    chk("instret_wrap", {29'd0, instret}, 32'd0);

    // beq not taken, then reset in the middle of a store wait.
    tick();                                  // FETCH -> DECODE
    drive(0, OP_B, 0, 1); tick();            // DECODE -> BEQ
    drive(0, OP_B, 0, 1); tick();            // BEQ -> FETCH
    chk("instret_after_beq", {29'd0, instret}, 32'd1);
    drive(0, OP_S, 0, 1); tick();            // FETCH
    drive(0, OP_S, 0, 1); tick();            // DECODE
    drive(0, OP_S, 0, 1); tick();            // MEMADR
    drive(0, OP_S, 0, 0);                    // MEMWRITE wait
    chk("sw_wait_mem_write", {31'd0, mem_write}, 32'd1);
    tick();
    drive(1, OP_S, 0, 1);                    // reset lands on the ready cycle
    chk("rst_gates_mem_write", {31'd0, mem_write}, 32'd0);
    chk("rst_gates_instr_done", {31'd0, instr_done}, 32'd0);
    tick();
    drive(0, OP_S, 0, 0);
    chk_fetch("fetch_after_rst");
    chk("mem_write_after_rst", {31'd0, mem_write}, 32'd0);
    chk("instret_after_rst", {29'd0, instret}, 32'd0);

    // One beq so the counter is non-zero before the illegal opcode.
    drive(0, OP_B, 0, 1); tick();
    drive(0, OP_B, 0, 1); tick();
    drive(0, OP_B, 0, 1); tick();
    chk("instret_pre_illegal", {29'd0, instret}, 32'd1);

    drive(0, OP_X, 0, 1); tick();            // FETCH
    drive(0, OP_X, 0, 1);                    // DECODE
    chk("illegal_decode_no_done", {31'd0, instr_done}, 32'd0);
    tick();
`ifdef ILLEGAL_TRAP_EN
    for (int k = 0; k < 3; k++) begin
      drive(0, OP_X, 1, 1);
      chk($sformatf("trap%0d.illegal", k), {31'd0, illegal_instr}, 32'd1);
      chk($sformatf("trap%0d.enables", k),
          {27'd0, pc_write, ir_write, mem_write, reg_write, instr_done}, 32'd0);
      chk($sformatf("trap%0d.instret", k), {29'd0, instret}, 32'd1);
      tick();
    end
    drive(1, OP_X, 0, 1); tick();
    drive(0, OP_R, 0, 0);
    chk("trap_cleared_by_rst", {31'd0, illegal_instr}, 32'd0);
    chk_fetch("fetch_after_trap_rst");
`else
    drive(0, OP_X, 0, 0);
    chk_fetch("illegal_back_to_fetch");
    chk("illegal_flag_tied_low", {31'd0, illegal_instr}, 32'd0);
    chk("illegal_instret_unchanged", {29'd0, instret}, 32'd1);
    tick();
    drive(0, OP_X, 0, 0);
    chk_fetch("illegal_fetch_holds");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
